// File: rtl/vproc_pkg.sv
// vproc_pkg: shared vector-processor types and the vreg hazard-conflict helper.
package vproc_pkg;
  typedef logic [31:0] vreg_mask;
  typedef enum logic [2:0] {UNIT_LSU, UNIT_ALU, UNIT_MUL, UNIT_SLD, UNIT_ELEM} op_unit;
  // RAW on reads, WAW/WAR on writes against the in-flight bitmaps
  function automatic logic vreg_conflict(vreg_mask rd, vreg_mask wr, vreg_mask pend_rd, vreg_mask pend_wr);
    return (|(rd & pend_wr)) | (|(wr & (pend_wr | pend_rd)));
  endfunction
endpackage

// File: rtl/vproc_hazard_tracker.sv
// vproc_hazard_tracker: single-entry issue buffer that holds an instruction until
// it is free of vreg RAW/WAR/WAW hazards and the in-flight limit allows issue.
module vproc_hazard_tracker
  import vproc_pkg::*;
#(
  parameter int unsigned ID_W            = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STALL_CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   async_rst_ni,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [ID_W-1:0]        instr_id_i,
  input  op_unit                 instr_unit_i,
  input  vreg_mask               instr_rd_hazards_i,
  input  vreg_mask               instr_wr_hazards_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [ID_W-1:0]        issue_id_o,
  output op_unit                 issue_unit_o,
  input  vreg_mask               wr_clear_i,
  input  vreg_mask               rd_clear_i,
  input  logic                   done_i,
  output vreg_mask               pend_wr_o,
  output vreg_mask               pend_rd_o,
  output logic [3:0]             outstanding_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  logic buf_valid_q, buf_valid_d;
  logic [ID_W-1:0] buf_id_q;
  op_unit buf_unit_q;
  vreg_mask buf_rd_q, buf_wr_q;
  vreg_mask pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d, eff_wr, eff_rd;
  logic [3:0] outstanding_q, outstanding_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic hazard, fire, accept, done_dec;
  // completions bypass into the check so a clear can release the buffer this cycle
  assign eff_wr        = pend_wr_q & ~wr_clear_i;
  assign eff_rd        = pend_rd_q & ~rd_clear_i;
  assign hazard        = vreg_conflict(buf_rd_q, buf_wr_q, eff_rd, eff_wr);
  assign issue_valid_o = buf_valid_q & !hazard & (outstanding_q < 4'(MAX_OUTSTANDING));
  assign fire          = issue_valid_o & issue_ready_i;
  assign instr_ready_o = !buf_valid_q | fire;
  assign accept        = instr_valid_i & instr_ready_o;
  assign done_dec      = done_i & (outstanding_q != 4'd0);
  assign issue_id_o    = buf_id_q;
  assign issue_unit_o  = buf_unit_q;
  assign pend_wr_o     = pend_wr_q;
  assign pend_rd_o     = pend_rd_q;
  assign outstanding_o = outstanding_q;
  assign stall_cnt_o   = stall_cnt_q;
  always_comb begin
    buf_valid_d   = accept | (buf_valid_q & !fire);
    pend_wr_d     = eff_wr | (fire ? buf_wr_q : '0);
    pend_rd_d     = eff_rd | (fire ? buf_rd_q : '0);
    outstanding_d = (fire & !done_dec) ? outstanding_q + 4'd1 :
                    (!fire & done_dec) ? outstanding_q - 4'd1 : outstanding_q;
    stall_cnt_d   = (buf_valid_q & hazard & ~&stall_cnt_q) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      buf_valid_q   <= 1'b0;
      pend_wr_q     <= '0;
      pend_rd_q     <= '0;
      outstanding_q <= 4'd0;
      stall_cnt_q   <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      pend_wr_q     <= pend_wr_d;
      pend_rd_q     <= pend_rd_d;
      outstanding_q <= outstanding_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_id_q   <= instr_id_i;
      buf_unit_q <= instr_unit_i;
      buf_rd_q   <= instr_rd_hazards_i;
      buf_wr_q   <= instr_wr_hazards_i;
    end
  end
endmodule
